// File: rtl/psg_env_timing.sv
// Clock-enable prescaler, envelope period divider and 32-level envelope shape
// generator for an AY-3-8910/YM2149-compatible PSG.
module psg_env_timing #(
  parameter int CLKDIV = 3,
  parameter int EGW    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic           sel,
  input  logic [EGW-1:0] eg_period,
  input  logic [3:0]     ctrl,
  input  logic           restart,
  output logic           cen16,
  output logic           cen256,
  output logic           eg_step,
  output logic [4:0]     env
);

  localparam int CW = CLKDIV + 5;

  // sel=0 adds one more prescale stage, so its masks are one bit wider.
  localparam logic [CW-1:0] MASK16_SEL1  = CW'((1 << CLKDIV) - 1);
  localparam logic [CW-1:0] MASK16_SEL0  = CW'((1 << (CLKDIV + 1)) - 1);
  localparam logic [CW-1:0] MASK256_SEL1 = CW'((1 << (CLKDIV + 4)) - 1);
  localparam logic [CW-1:0] MASK256_SEL0 = CW'((1 << (CLKDIV + 5)) - 1);

  typedef enum logic {
    ENV_RUN  = 1'b0,
    ENV_HOLD = 1'b1
  } env_state_t;

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cen16_q, cen16_d;
  logic           cen256_q, cen256_d;
  logic [EGW-1:0] count_q, count_d;
  logic           eg_step_q, eg_step_d;
  logic [4:0]     gain_q, gain_d;
  logic           inv_q, inv_d;
  env_state_t     state_q, state_d;
  logic           last_step_q, last_step_d;
  logic           latch_q, latch_d;
  logic [4:0]     env_q, env_d;

  logic [CW-1:0]  mask16;
  logic [CW-1:0]  mask256;
  logic           step_edge;
  logic           will_hold;
  logic           will_invert;

  always_comb begin
    mask16   = sel ? MASK16_SEL1 : MASK16_SEL0;
    mask256  = sel ? MASK256_SEL1 : MASK256_SEL0;
    cen16_d  = clk_en & ((cnt_q & mask16) == '0);
    cen256_d = clk_en & ((cnt_q & mask256) == '0);
    cnt_d    = clk_en ? cnt_q + 1'b1 : cnt_q;
  end

  // Period 0 and 1 both satisfy count >= period immediately, so both toggle on every cen256.
  always_comb begin
    count_d   = count_q;
    eg_step_d = eg_step_q;
    if (cen256_q) begin
      if (count_q >= eg_period) begin
        count_d   = {{(EGW-1){1'b0}}, 1'b1};
        eg_step_d = ~eg_step_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_comb begin
    step_edge   = (eg_step_q & ~last_step_q) | (eg_period == '0);
    will_hold   = ~ctrl[3] | ctrl[0];
    will_invert = (~ctrl[3] & ctrl[2]) | (ctrl[3] & ctrl[1]);
  end

  // A pending restart wins over stepping; a restart in the clearing cycle keeps the latch set.
  always_comb begin
    gain_d      = gain_q;
    inv_d       = inv_q;
    state_d     = state_q;
    last_step_d = last_step_q;
    env_d       = env_q;
    latch_d     = latch_q;
    if (cen256_q) begin
      env_d       = inv_q ? ~gain_q : gain_q;
      last_step_d = eg_step_q;
      latch_d     = 1'b0;
      if (latch_q) begin
        gain_d  = 5'd31;
        inv_d   = ctrl[2];
        state_d = ENV_RUN;
      end else if (step_edge && (state_q == ENV_RUN)) begin
        if (gain_q != 5'd0) begin
          gain_d = gain_q - 5'd1;
        end else begin
          if (will_hold) begin
            state_d = ENV_HOLD;
          end else begin
            gain_d = 5'd31;
          end
          if (will_invert) begin
            inv_d = ~inv_q;
          end
        end
      end
    end
    if (restart) begin
      latch_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cen16_q     <= 1'b0;
      cen256_q    <= 1'b0;
      count_q     <= {{(EGW-1){1'b0}}, 1'b1};
      eg_step_q   <= 1'b0;
      gain_q      <= 5'd31;
      inv_q       <= 1'b0;
      state_q     <= ENV_RUN;
      last_step_q <= 1'b0;
      latch_q     <= 1'b0;
      env_q       <= 5'd31;
    end else begin
      cnt_q       <= cnt_d;
      cen16_q     <= cen16_d;
      cen256_q    <= cen256_d;
      count_q     <= count_d;
      eg_step_q   <= eg_step_d;
      gain_q      <= gain_d;
      inv_q       <= inv_d;
      state_q     <= state_d;
      last_step_q <= last_step_d;
      latch_q     <= latch_d;
      env_q       <= env_d;
    end
  end

  assign cen16   = cen16_q;
  assign cen256  = cen256_q;
  assign eg_step = eg_step_q;
  assign env     = env_q;

endmodule

// File: tb/tb_psg_env_timing.sv
// Randomized bench for psg_env_timing against a closed-form envelope and
// clock-enable-count model.
module tb_psg_env_timing;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] eg_period = 16'd0;
  logic [3:0]  ctrl = 4'd0;
  logic        restart = 1'b0;
  logic        cen16;
  logic        cen256;
  logic        eg_step;
  logic [4:0]  env;

  int checks = 0;
  int errors = 0;

  psg_env_timing #(.CLKDIV(3), .EGW(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .sel(sel),
    .eg_period(eg_period),
    .ctrl(ctrl),
    .restart(restart),
    .cen16(cen16),
    .cen256(cen256),
    .eg_step(eg_step),
    .env(env)
  );

  always #5 clk = ~clk;

  int       en_cnt;
  bit       m_cen16, m_cen256, m_eg, m_last, m_latch;
  int       m_div;
  int       k;
  bit       start_inv;
  logic [3:0] shape;
  int       m_env;
  int       cyc;
  bit       phase_a = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Envelope level after kk steps since a (re)start, from the shape rules.
  function automatic int level(input int kk, input bit sinv, input logic [3:0] sh);
    bit hold;
    bit winv;
    int g;
    bit iv;
    hold = !sh[3] || sh[0];
    winv = (!sh[3] && sh[2]) || (sh[3] && sh[1]);
    if (hold && kk >= 32) begin
      g  = 0;
      iv = sinv ^ winv;
    end else begin
      g  = 31 - (kk % 32);
      iv = sinv ^ (winv && ((kk / 32) % 2 == 1));
    end
    return iv ? 31 - g : g;
  endfunction

  always @(posedge clk) begin
    bit step;
    bit n16;
    bit n256;
    if (!rst_n) begin
      en_cnt = 0; m_cen16 = 0; m_cen256 = 0; m_eg = 0; m_last = 0; m_latch = 0;
      m_div = 1; k = 0; start_inv = 0; shape = ctrl; m_env = 31; cyc = 0;
    end else begin
      cyc++;
      if (m_cen256) begin
        step  = (m_eg && !m_last) || (eg_period == 16'd0);
        m_env = level(k, start_inv, shape);
        if (m_latch) begin
          k = 0; start_inv = ctrl[2]; shape = ctrl;
        end else if (step) begin
          k++;
        end
        m_last = m_eg;
        if (m_div >= int'(eg_period)) begin
          m_div = 1; m_eg = !m_eg;
        end else begin
          m_div++;
        end
        m_latch = 0;
      end
      if (restart) m_latch = 1;
      n16  = clk_en && ((en_cnt % (sel ? 8 : 16)) == 0);
      n256 = clk_en && ((en_cnt % (sel ? 128 : 256)) == 0);
      if (clk_en) en_cnt++;
      m_cen16  = n16;
      m_cen256 = n256;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_output("cen16", 32'(cen16), 32'(m_cen16));
      check_output("cen256", 32'(cen256), 32'(m_cen256));
      check_output("eg_step", 32'(eg_step), 32'(m_eg));
      check_output("env", 32'(env), 32'(m_env));
      if (phase_a) begin
        if (cyc == 1) begin
          check_output("lit_cen16_c1", 32'(cen16), 32'd1);
          check_output("lit_cen256_c1", 32'(cen256), 32'd1);
          check_output("lit_env_reset", 32'(env), 32'd31);
        end
        if (cyc == 2) begin
          check_output("lit_cen16_c2", 32'(cen16), 32'd0);
          check_output("lit_cen256_c2", 32'(cen256), 32'd0);
        end
        if (cyc == 5) check_output("lit_egstep_c5", 32'(eg_step), 32'd1);
        if (cyc == 17) check_output("lit_cen16_c17", 32'(cen16), 32'd1);
        if (cyc == 33) check_output("lit_cen16_c33", 32'(cen16), 32'd1);
        if (cyc == 256) check_output("lit_cen256_c256", 32'(cen256), 32'd0);
        if (cyc == 257) check_output("lit_cen256_c257", 32'(cen256), 32'd1);
        if (cyc == 258) check_output("lit_env_c258", 32'(env), 32'd30);
        if (cyc == 260) check_output("lit_egstep_c260", 32'(eg_step), 32'd0);
      end
    end
  end

  // Restart only on a cycle whose coming edge is not a cen256 edge.
  task automatic apply_stimulus(input logic [3:0] sh);
    int tries;
    tries = 0;
    while (cen256 && tries < 4) begin
      @(negedge clk);
      tries++;
    end
    if (cen256) begin
      checks++;
      errors++;
      $display("[TB] FAIL restart_wait: cen256 stayed %0d expected 0", cen256);
    end
    ctrl    = sh;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  logic [3:0] shapes [8] = '{4'h0, 4'h4, 4'h8, 4'hB, 4'hD, 4'hE, 4'hA, 4'hC};
  int         held   [8] = '{0, 0, -1, 31, 31, -1, -1, -1};

  initial begin
    ctrl = 4'h0; eg_period = 16'd0; sel = 1'b0; clk_en = 1'b1; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    phase_a = 1'b1;
    repeat (300) @(negedge clk);
    phase_a = 1'b0;

    sel = 1'b1;
    for (int s = 0; s < 8; s++) begin
      apply_stimulus(shapes[s]);
      repeat (36 * 128) @(negedge clk);
      if (held[s] >= 0) check_output("held_level", 32'(env), 32'(held[s]));
    end

    sel = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      clk_en = (i % 4 == 0);
      if ($urandom_range(0, 499) == 0) eg_period = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 1999) == 0 && !cen256) begin
        ctrl = 4'($urandom_range(0, 15));
        restart = 1'b1;
      end else begin
        restart = 1'b0;
      end
      @(negedge clk);
    end
    restart = 1'b0;

    for (int i = 0; i < 5000; i++) begin
      clk_en = 1'($urandom_range(0, 1));
      if (i % 300 == 0) sel = 1'($urandom_range(0, 1));
      if (i % 700 == 0) eg_period = 16'($urandom_range(0, 2));
      if ($urandom_range(0, 999) == 0 && !cen256) begin
        ctrl = 4'($urandom_range(0, 15));
        restart = 1'b1;
      end else begin
        restart = 1'b0;
      end
      @(negedge clk);
    end
    restart = 1'b0;

    clk_en = 1'b1;
    sel    = 1'b1;
    eg_period = 16'd0;
    apply_stimulus(4'h4);
    repeat (6 * 128) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_env", 32'(env), 32'd31);
    check_output("async_egstep", 32'(eg_step), 32'd0);
    check_output("async_cen16", 32'(cen16), 32'd0);
    check_output("async_cen256", 32'(cen256), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    eg_period = 16'd3;
    repeat (1200) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
